// File: rtl/dtw_top.sv
// DTW accelerator: loads a 20-sample query, fetches the template from SRAM, writes the full cost matrix back.
// One read + one write per cell below row 0 (3 cycles/cell); dtw_valid is only honoured in IDLE.
module dtw_top #(
   parameter int N      = 20,
   parameter int DW     = 32,
   parameter int AW     = 10,
   parameter int T_BASE = 0,
   parameter int D_BASE = 20
) (
   input  logic          clk,
   input  logic          nrst,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_data_ena,
   output logic          mem_wr,
   output logic          mem_cs,
   input  logic [DW-1:0] dtw_in,
   input  logic          dtw_valid,
   output logic          dtw_ready
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

   state_t        state;
   logic [1:0]    phase;
   logic [IW-1:0] cnt;
   logic [IW-1:0] row;
   logic [IW-1:0] col;
   logic [AW-1:0] waddr;
   logic [DW-1:0] r_mem [N];
   logic [DW-1:0] t_mem [N];
   logic [DW-1:0] left_dat;
   logic [DW-1:0] diag_dat;

   logic [DW-1:0] r_cur;
   logic [DW-1:0] t_cur;
   logic [DW-1:0] d_abs;
   logic [DW-1:0] best;
   logic [DW-1:0] cost;

   // mem_rdata holds D[row-1][col] during the write phase of rows > 0
   always_comb begin
      r_cur = r_mem[row];
      t_cur = t_mem[col];
      d_abs = (r_cur >= t_cur) ? (r_cur - t_cur) : (t_cur - r_cur);
      best  = mem_rdata;
      if (left_dat < best) best = left_dat;
      if (diag_dat < best) best = diag_dat;
      if (row == '0 && col == '0) cost = d_abs;
      else if (row == '0)         cost = d_abs + left_dat;
      else if (col == '0)         cost = d_abs + mem_rdata;
      else                        cost = d_abs + best;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state        <= IDLE;
         phase        <= '0;
         cnt          <= '0;
         row          <= '0;
         col          <= '0;
         waddr        <= '0;
         mem_cs       <= 1'b1;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_data_ena <= 1'b0;
         dtw_ready    <= 1'b0;
      end else begin
         mem_cs       <= 1'b1;
         mem_wr       <= 1'b0;
         mem_data_ena <= 1'b0;
         case (state)
            IDLE: begin
               if (dtw_valid) begin
                  r_mem[cnt] <= dtw_in;
                  dtw_ready  <= 1'b0;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     phase <= '0;
                     state <= FETCH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FETCH: begin
               case (phase)
                  2'd0: begin
                     mem_cs   <= 1'b0;
                     mem_addr <= AW'(T_BASE) + AW'(cnt);
                     phase    <= 2'd1;
                  end
                  2'd1: phase <= 2'd2;
                  default: begin
                     t_mem[cnt] <= mem_rdata;
                     phase      <= 2'd0;
                     if (cnt == LAST) begin
                        cnt   <= '0;
                        row   <= '0;
                        col   <= '0;
                        waddr <= AW'(D_BASE);
                        state <= COMPUTE;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               endcase
            end
            COMPUTE: begin
               if (phase == 2'd0 && row != '0) begin
                  mem_cs   <= 1'b0;
                  mem_addr <= waddr - AW'(N);
                  phase    <= 2'd1;
               end else if (phase == 2'd1) begin
                  phase <= 2'd2;
               end else begin
                  // the cell just read as "up" becomes "diag" for the next column
                  mem_cs       <= 1'b0;
                  mem_wr       <= 1'b1;
                  mem_data_ena <= 1'b1;
                  mem_addr     <= waddr;
                  mem_wdata    <= cost;
                  left_dat     <= cost;
                  diag_dat     <= mem_rdata;
                  waddr        <= waddr + 1'b1;
                  phase        <= 2'd0;
                  if (col == LAST) begin
                     col <= '0;
                     if (row == LAST) state <= DONE;
                     else             row   <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DONE: begin
               dtw_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtw_top.sv
// Bench for dtw_top: SRAM model, golden DTW matrix pushed to a write scoreboard per query.
// Writes are popped and compared as the DUT issues them; D region and bus rules checked after each job.
module tb_dtw_top;

   localparam int N      = 20;
   localparam int DW     = 32;
   localparam int AW     = 10;
   localparam int T_BASE = 0;
   localparam int D_BASE = 20;

   logic          clk = 1'b0;
   logic          nrst;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] mem_wdata;
   logic          mem_data_ena;
   logic          mem_wr;
   logic          mem_cs;
   logic [DW-1:0] dtw_in;
   logic          dtw_valid;
   logic          dtw_ready;

   always #5 clk = ~clk;

   dtw_top #(.N(N), .DW(DW), .AW(AW), .T_BASE(T_BASE), .D_BASE(D_BASE)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_wdata    (mem_wdata),
      .mem_data_ena (mem_data_ena),
      .mem_wr       (mem_wr),
      .mem_cs       (mem_cs),
      .dtw_in       (dtw_in),
      .dtw_valid    (dtw_valid),
      .dtw_ready    (dtw_ready)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } wr_t;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] tq [N];
   logic [DW-1:0] rq [N];
   logic [DW-1:0] gd [N][N];
   logic          pre_vld;
   wr_t           exp_q [$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            ena_err = 0;
   int            idle_err = 0;
   int            oob_err = 0;
   bit            quiet;

   // SRAM model; pre_vld loads the whole template in one cycle while the DUT is idle
   always @(posedge clk) begin
      if (pre_vld) begin
         for (int j = 0; j < N; j++) mem[T_BASE + j] <= tq[j];
      end else if (!mem_cs) begin
         if (mem_wr) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (mem_data_ena !== (!mem_cs && mem_wr)) ena_err++;
         if (quiet && !mem_cs) idle_err++;
         if (!mem_cs && mem_wr) begin
            if (int'(mem_addr) < D_BASE || int'(mem_addr) >= D_BASE + N*N) oob_err++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {54'd0, mem_addr}, 64'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
               chk("wr_dat", {32'd0, mem_wdata}, {32'd0, e.dat});
            end
         end
      end
   endtask

   task automatic build_exp();
      logic [DW-1:0] d;
      logic [DW-1:0] m;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            d = (rq[i] >= tq[j]) ? rq[i] - tq[j] : tq[j] - rq[i];
            if (i == 0 && j == 0) gd[i][j] = d;
            else if (i == 0)      gd[i][j] = d + gd[i][j-1];
            else if (j == 0)      gd[i][j] = d + gd[i-1][j];
            else begin
               m = gd[i-1][j];
               if (gd[i][j-1] < m)   m = gd[i][j-1];
               if (gd[i-1][j-1] < m) m = gd[i-1][j-1];
               gd[i][j] = d + m;
            end
            exp_q.push_back('{addr: AW'(D_BASE + N*i + j), dat: gd[i][j]});
         end
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_cs"},    {63'd0, mem_cs}, 64'd1);
      chk({tag, "_wr"},    {63'd0, mem_wr}, 64'd0);
      chk({tag, "_addr"},  {54'd0, mem_addr}, 64'd0);
      chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
      chk({tag, "_ena"},   {63'd0, mem_data_ena}, 64'd0);
      chk({tag, "_ready"}, {63'd0, dtw_ready}, 64'd0);
   endtask

   // abort_after > 0 resets the DUT that many cycles after the last sample
   task automatic feed(input bit gaps, input int abort_after);
      int cyc;
      int bad;
      @(negedge clk); pre_vld = 1'b1;
      @(negedge clk); pre_vld = 1'b0;
      build_exp();
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               dtw_valid = 1'b0; dtw_in = $urandom; @(negedge clk);
            end
         end
         if (i == N-1) quiet = 1'b0;
         dtw_valid = 1'b1; dtw_in = rq[i];
         @(negedge clk);
         if (i == 0) chk("ready_low_after_first", {63'd0, dtw_ready}, 64'd0);
      end
      dtw_valid = 1'b0; dtw_in = $urandom;
      if (abort_after > 0) begin
         repeat (abort_after) @(negedge clk);
         nrst = 1'b1;
         @(negedge clk);
         nrst = 1'b0;
         exp_q.delete();
         chk_reset_outs("abort");
         quiet = 1'b1;
         return;
      end
      cyc = 0;
      while (!dtw_ready && cyc < 2000) begin
         dtw_valid = 1'($urandom_range(0, 1)); dtw_in = $urandom;
         @(negedge clk);
         cyc++;
      end
      dtw_valid = 1'b0;
      quiet = 1'b1;
      chk("ready_in_time", {63'd0, dtw_ready}, 64'd1);
      chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (mem[D_BASE + N*i + j] !== gd[i][j]) bad++;
      chk("d_region", 64'(bad), 64'd0);
   endtask

   initial begin
      int cs_low;
      int rdy_hi;
      int bad;
      nrst = 1'b1; dtw_valid = 1'b0; dtw_in = '0; pre_vld = 1'b0; quiet = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      nrst = 1'b0;

      cs_low = 0; rdy_hi = 0;
      repeat (300) begin
         dtw_in = $urandom;
         @(negedge clk);
         if (!mem_cs) cs_low++;
         if (dtw_ready) rdy_hi++;
      end
      chk("garbage_cs_low", 64'(cs_low), 64'd0);
      chk("garbage_ready", 64'(rdy_hi), 64'd0);

      for (int k = 0; k < N; k++) begin tq[k] = '0; rq[k] = 32'd1; end
      feed(1'b0, 0);
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (mem[D_BASE + N*i + j] !== DW'(((i > j) ? i : j) + 1)) bad++;
      chk("ones_maxij", 64'(bad), 64'd0);
      chk("ones_mem419", {32'd0, mem[419]}, 64'd20);
      repeat (5) @(negedge clk);
      chk("ready_held", {63'd0, dtw_ready}, 64'd1);

      for (int k = 0; k < N; k++) begin tq[k] = DW'(k); rq[k] = DW'(k); end
      feed(1'b1, 0);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[D_BASE + N*i + i] !== '0) bad++;
      for (int j = 0; j < N; j++) if (mem[D_BASE + j] !== DW'(j*(j+1)/2)) bad++;
      chk("ramp_diag_row0", 64'(bad), 64'd0);
      chk("ramp_mem419", {32'd0, mem[419]}, 64'd0);

      for (int k = 0; k < N; k++) begin tq[k] = '0; rq[k] = '0; end
      rq[0] = 32'hFFFF_FFFF; rq[1] = 32'd2;
      feed(1'b0, 0);
      chk("wrap_mem20", {32'd0, mem[20]}, 64'hFFFF_FFFF);
      chk("wrap_mem40", {32'd0, mem[40]}, 64'h1);

      for (int k = 0; k < N; k++) begin tq[k] = $urandom; rq[k] = $urandom; end
      feed(1'b0, 300);
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin tq[k] = $urandom_range(0, 500); rq[k] = $urandom_range(0, 500); end
      feed(1'b0, 0);

      for (int q = 0; q < 20; q++) begin
         repeat (8) @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (q % 3 == 0) begin tq[k] = $urandom; rq[k] = $urandom; end
            else begin tq[k] = $urandom_range(0, 1000); rq[k] = $urandom_range(0, 1000); end
         end
         feed(1'(q % 2), 0);
      end

      chk("data_ena_rule", 64'(ena_err), 64'd0);
      chk("idle_access", 64'(idle_err), 64'd0);
      chk("write_range", 64'(oob_err), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
